// File: rtl/vga_controller_if.sv
// rtl/vga_controller_if.sv - VGA timing bundle between the controller and the pixel/DAC side
interface vga_controller_if;
    logic       en;
    logic       vgaclk;
    logic       hsync;
    logic       vsync;
    logic       sync_b;
    logic       blank_b;
    logic [9:0] x;
    logic [9:0] y;
    logic       frame_start;

    modport master (
        input  en,
        output vgaclk, hsync, vsync, sync_b, blank_b, x, y, frame_start
    );

    modport slave (
        output en,
        input  vgaclk, hsync, vsync, sync_b, blank_b, x, y, frame_start
    );
endinterface

// File: rtl/vga_controller.sv
// rtl/vga_controller.sv - VGA raster timing: pixel clock at clk/2, x/y counters, registered syncs
module vga_controller #(
    parameter int HACTIVE = 640,
    parameter int HFP     = 16,
    parameter int HSYN    = 96,
    parameter int HBP     = 48,
    parameter int VACTIVE = 480,
    parameter int VFP     = 10,
    parameter int VSYN    = 2,
    parameter int VBP     = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    vga_controller_if.master vga
);
    localparam int HMAX = HACTIVE + HFP + HSYN + HBP;
    localparam int VMAX = VACTIVE + VFP + VSYN + VBP;

    localparam logic [9:0] X_LAST   = 10'(HMAX - 1);
    localparam logic [9:0] Y_LAST   = 10'(VMAX - 1);
    localparam logic [9:0] H_ACT    = 10'(HACTIVE);
    localparam logic [9:0] V_ACT    = 10'(VACTIVE);
    localparam logic [9:0] HS_START = 10'(HACTIVE + HFP);
    localparam logic [9:0] HS_END   = 10'(HACTIVE + HFP + HSYN);
    localparam logic [9:0] VS_START = 10'(VACTIVE + VFP);
    localparam logic [9:0] VS_END   = 10'(VACTIVE + VFP + VSYN);

    logic       vgaclk_q, vgaclk_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       blank_b_q, blank_b_d;
    logic       frame_start_q, frame_start_d;

    // A tick is the clk edge on which vgaclk falls; everything else moves only then.
    always_comb begin
        vgaclk_d      = ~vgaclk_q;
        x_d           = x_q;
        y_d           = y_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        blank_b_d     = blank_b_q;
        frame_start_d = frame_start_q;
        if (vgaclk_q && vga.en) begin
            if (x_q == X_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
            // Decoded from the next position so syncs line up with x/y in the same period.
            hsync_d       = !((x_d >= HS_START) && (x_d < HS_END));
            vsync_d       = !((y_d >= VS_START) && (y_d < VS_END));
            blank_b_d     = (x_d < H_ACT) && (y_d < V_ACT);
            frame_start_d = (x_d == 10'd0) && (y_d == 10'd0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vgaclk_q      <= 1'b0;
            x_q           <= 10'd0;
            y_q           <= 10'd0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            blank_b_q     <= 1'b1;
            frame_start_q <= 1'b1;
        end else begin
            vgaclk_q      <= vgaclk_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            blank_b_q     <= blank_b_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.vgaclk      = vgaclk_q;
    assign vga.x           = x_q;
    assign vga.y           = y_q;
    assign vga.hsync       = hsync_q;
    assign vga.vsync       = vsync_q;
    assign vga.blank_b     = blank_b_q;
    assign vga.frame_start = frame_start_q;
    assign vga.sync_b      = 1'b0;
endmodule

// File: tb/tb_vga_controller.sv
// tb/tb_vga_controller.sv - random-enable bench for vga_controller, default and shrunken timings
module tb_vga_controller;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic en    = 1'b0;

    always #10 clk = ~clk;

    vga_controller_if ifd ();
    vga_controller_if ifs ();
    assign ifd.en = en;
    assign ifs.en = en;

    vga_controller dut_d (.clk(clk), .rst_n(rst_n), .vga(ifd.master));

    vga_controller #(
        .HACTIVE(16), .HFP(4), .HSYN(6), .HBP(4),
        .VACTIVE(10), .VFP(2), .VSYN(2), .VBP(3)
    ) dut_s (.clk(clk), .rst_n(rst_n), .vga(ifs.master));

    localparam int D_HM = 800, D_VM = 525;
    localparam int S_HM = 30,  S_VM = 17;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       hs;
        logic       vs;
        logic       bl;
        logic       fs;
    } exp_t;

    int n_checks = 0;
    int n_errors = 0;

    // Model: raster position is just a tick count modulo the frame size.
    int pos_d = 0;
    int pos_s = 0;
    bit mvclk = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t expv(input int pos, input int ha, input int hf, input int hs,
                                  input int hb, input int va, input int vf, input int vs);
        exp_t e;
        int   hm = ha + hf + hs + hb;
        int   xx = pos % hm;
        int   yy = pos / hm;
        e.x  = 10'(xx);
        e.y  = 10'(yy);
        e.hs = !(xx >= ha + hf && xx < ha + hf + hs);
        e.vs = !(yy >= va + vf && yy < va + vf + vs);
        e.bl = (xx < ha) && (yy < va);
        e.fs = (xx == 0) && (yy == 0);
        return e;
    endfunction

    task automatic cmp_dut(input string p, input exp_t e, input logic [9:0] ox, input logic [9:0] oy,
                           input logic vc, input logic hs, input logic vs, input logic bl,
                           input logic fs, input logic sb);
        check_eq({p, "_vgaclk"}, 32'(vc), 32'(mvclk));
        check_eq({p, "_x"}, 32'(ox), 32'(e.x));
        check_eq({p, "_y"}, 32'(oy), 32'(e.y));
        check_eq({p, "_hsync"}, 32'(hs), 32'(e.hs));
        check_eq({p, "_vsync"}, 32'(vs), 32'(e.vs));
        check_eq({p, "_blank_b"}, 32'(bl), 32'(e.bl));
        check_eq({p, "_frame_start"}, 32'(fs), 32'(e.fs));
        check_eq({p, "_sync_b"}, 32'(sb), 32'd0);
    endtask

    task automatic compare_all();
        cmp_dut("d", expv(pos_d, 640, 16, 96, 48, 480, 10, 2),
                ifd.x, ifd.y, ifd.vgaclk, ifd.hsync, ifd.vsync, ifd.blank_b, ifd.frame_start, ifd.sync_b);
        cmp_dut("s", expv(pos_s, 16, 4, 6, 4, 10, 2, 2),
                ifs.x, ifs.y, ifs.vgaclk, ifs.hsync, ifs.vsync, ifs.blank_b, ifs.frame_start, ifs.sync_b);
    endtask

    task automatic step();
        @(posedge clk);
        if (rst_n) begin
            if (mvclk && en) begin
                pos_d = (pos_d + 1) % (D_HM * D_VM);
                pos_s = (pos_s + 1) % (S_HM * S_VM);
            end
            mvclk = !mvclk;
        end
        @(negedge clk);
        compare_all();
    endtask

    int cnt_a, cnt_b, cnt_c, guard;
    logic [9:0] sx, sy;
    logic       last_vc;

    initial begin
        // Reset held, then release with en=1
        step();
        step();
        rst_n = 1'b1;
        en    = 1'b1;
        step();
        check_eq("first_edge_vgaclk", 32'(ifs.vgaclk), 32'd1);
        check_eq("first_edge_fs", 32'(ifs.frame_start), 32'd1);
        step();
        check_eq("second_edge_x", 32'(ifs.x), 32'd1);
        check_eq("second_edge_fs", 32'(ifs.frame_start), 32'd0);

        // Randomized enable
        for (int i = 0; i < 4000; i++) begin
            en = ($urandom_range(0, 7) != 0);
            step();
        end

        // Periodic windows with en held high
        en = 1'b1;
        cnt_a = 0;
        for (int i = 0; i < 2 * D_HM; i++) begin
            step();
            if (!ifd.hsync) cnt_a++;
        end
        check_eq("d_hsync_low_per_line", 32'(cnt_a), 32'(2 * 96));
        cnt_b = 0;
        cnt_c = 0;
        for (int i = 0; i < 2 * S_HM * S_VM; i++) begin
            step();
            if (!ifs.vsync) cnt_b++;
            if (ifs.frame_start) cnt_c++;
        end
        check_eq("s_vsync_low_per_frame", 32'(cnt_b), 32'(2 * 2 * S_HM));
        check_eq("s_frame_start_per_frame", 32'(cnt_c), 32'd2);

        // Freeze with en=0 for 10 ticks
        guard = 0;
        while (!((pos_s % S_HM) == 5 && (pos_s / S_HM) == 3) && guard < 2000) begin
            step();
            guard++;
        end
        check_eq("reach_freeze_point", 32'(guard < 2000), 32'd1);
        sx = ifs.x;
        sy = ifs.y;
        en = 1'b0;
        cnt_a = 0;
        last_vc = ifs.vgaclk;
        for (int i = 0; i < 20; i++) begin
            step();
            if (ifs.vgaclk != last_vc) cnt_a++;
            last_vc = ifs.vgaclk;
        end
        check_eq("freeze_x", 32'(ifs.x), 32'(sx));
        check_eq("freeze_y", 32'(ifs.y), 32'(sy));
        check_eq("freeze_vgaclk_toggles", 32'(cnt_a), 32'd20);
        en = 1'b1;
        step();
        step();
        check_eq("resume_x", 32'(ifs.x), 32'd6);

        // Asynchronous reset mid-frame inside both sync pulses
        guard = 0;
        while (!((pos_s % S_HM) == 22 && (pos_s / S_HM) == 12) && guard < 2000) begin
            step();
            guard++;
        end
        check_eq("reach_sync_point", 32'(guard < 2000), 32'd1);
        check_eq("pre_reset_hsync", 32'(ifs.hsync), 32'd0);
        check_eq("pre_reset_vsync", 32'(ifs.vsync), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        pos_d = 0;
        pos_s = 0;
        mvclk = 1'b0;
        compare_all();
        step();
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 200; i++) begin
            en = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_controller.md
VGA_CONTROLLER -- requirements
Module: vga_controller

Interface
REQ-001 SHALL declare parameter HACTIVE, 640, visible pixels per line.
REQ-002 SHALL declare parameter HFP, 16, horizontal front porch in pixels.
REQ-003 SHALL declare parameter HSYN, 96, hsync pulse width in pixels.
REQ-004 SHALL declare parameter HBP, 48, horizontal back porch in pixels.
REQ-005 SHALL declare parameter VACTIVE, 480, visible lines per frame.
REQ-006 SHALL declare parameter VFP, 10, vertical front porch in lines.
REQ-007 SHALL declare parameter VSYN, 2, vsync pulse width in lines.
REQ-008 SHALL declare parameter VBP, 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, 50 MHz system clock; all flops rising-edge on clk.
REQ-010 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-011 SHALL have port en, input, 1, counter run enable.
REQ-012 SHALL have port vgaclk, output, 1, pixel clock to DAC, clk/2.
REQ-013 SHALL have port hsync, output, 1, horizontal sync, active low.
REQ-014 SHALL have port vsync, output, 1, vertical sync, active low.
REQ-015 SHALL have port sync_b, output, 1, composite sync to DAC, tied 0.
REQ-016 SHALL have port blank_b, output, 1, high inside visible area.
REQ-017 SHALL have port x, output, 10, current pixel column, feeds pixel generator.
REQ-018 SHALL have port y, output, 10, current line, feeds pixel generator.
REQ-019 SHALL have port frame_start, output, 1, one-vgaclk-period pulse at x=0,y=0.

Function
REQ-020 SHALL derive HMAX=HACTIVE+HFP+HSYN+HBP (800) and VMAX=VACTIVE+VFP+VSYN+VBP (525).
REQ-021 SHALL toggle vgaclk every clk edge while rst_n high, regardless of en.
REQ-022 SHALL define tick as clk edge where vgaclk is 1 before the edge (vgaclk 1->0); all x/y/sync updates occur only on ticks.
REQ-023 SHALL, on tick with en=1, increment x; at x=HMAX-1 wrap x to 0 and increment y.
REQ-024 SHALL, when x wraps and y=VMAX-1, wrap y to 0.
REQ-025 SHALL hold x, y, hsync, vsync, blank_b, frame_start values on ticks with en=0; vgaclk keeps toggling.
REQ-026 SHALL register hsync, vsync, blank_b, frame_start from next-state x/y so they align with x/y in the same vgaclk period (zero relative latency).
REQ-027 SHALL drive hsync=0 iff HACTIVE+HFP <= x < HACTIVE+HFP+HSYN (656..751), else 1.
REQ-028 SHALL drive vsync=0 iff VACTIVE+VFP <= y < VACTIVE+VFP+VSYN (490..491), else 1.
REQ-029 SHALL drive blank_b=1 iff x<HACTIVE and y<VACTIVE.
REQ-030 SHALL drive frame_start=1 iff x=0 and y=0, lasting exactly 2 clk cycles per frame when en=1.
REQ-031 SHALL compare using 10-bit unsigned arithmetic; x never exceeds HMAX-1, y never exceeds VMAX-1.
REQ-032 SHALL keep sync_b constant 0.

Reset
REQ-033 SHALL, on rst_n low, asynchronously set vgaclk=0, x=0, y=0, hsync=1, vsync=1, blank_b=1, frame_start=1.
REQ-034 SHALL, after rst_n deasserts, produce first vgaclk rise on the first clk edge and first tick on the second clk edge.
REQ-035 SHALL, on reset mid-frame, abandon the frame and restart from x=0,y=0 with no partial sync pulse carried over.

Verification
REQ-036 SHALL cover reset release, en=1: vgaclk 0,1,0,1...; x=1 after 2nd clk edge; frame_start high for clk edges 0-1 only.
REQ-037 SHALL cover one full line: hsync low for exactly 96 ticks beginning when x becomes 656; blank_b falls when x becomes 640.
REQ-038 SHALL cover line/frame wrap: x=799,y=524 -> next tick x=0,y=0, frame_start=1, vsync=1, blank_b=1.
REQ-039 SHALL cover vertical sync: vsync low exactly for y=490,491, i.e. 1600 ticks per frame; frame period 420000 ticks.
REQ-040 SHALL cover en=0 for 10 ticks at x=300,y=100 -> x,y frozen, vgaclk still toggling; resumes x=301 on first tick after en=1.
REQ-041 SHALL cover rst_n asserted at x=700,y=491 (hsync, vsync low) -> immediately x=0,y=0, hsync=1, vsync=1 without waiting for clk.
